// File: rtl/ctl_pkg.sv
// rtl/ctl_pkg.sv - shared opcodes, encodings and control bundle for the decode-control stage
package ctl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] FMT_NONE = 6'b000000;
  localparam logic [5:0] FMT_R    = 6'b000001;
  localparam logic [5:0] FMT_I    = 6'b000010;
  localparam logic [5:0] FMT_S    = 6'b000100;
  localparam logic [5:0] FMT_B    = 6'b001000;
  localparam logic [5:0] FMT_U    = 6'b010000;
  localparam logic [5:0] FMT_J    = 6'b100000;

  localparam logic [2:0] BJ_NONE = 3'b010;
  localparam logic [2:0] BJ_JUMP = 3'b011;

  localparam logic [1:0] ALU_DEF   = 2'b00;
  localparam logic [1:0] ALU_IMM   = 2'b01;
  localparam logic [1:0] ALU_ILL   = 2'b10;
  localparam logic [1:0] ALU_STORE = 2'b11;

  localparam logic [1:0] USEL_NONE  = 2'b00;
  localparam logic [1:0] USEL_LUI   = 2'b01;
  localparam logic [1:0] USEL_AUIPC = 2'b10;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [1:0] u_sel;
    logic [5:0] i_format;
    logic [2:0] bj_type;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       muldiv;
    logic       illegal;
    logic [4:0] rd;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{
    u_sel: USEL_NONE, i_format: FMT_NONE, bj_type: BJ_NONE, alu_op: ALU_DEF,
    mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
    reg_write: 1'b0, muldiv: 1'b0, illegal: 1'b0, rd: 5'd0
  };

  // SUB/SRA are the only alternate-funct7 R-type ops in the base ISA
  function automatic logic r_funct7_ok(input logic [6:0] funct7, input logic [2:0] funct3,
                                       input logic m_en);
    case (funct7)
      F7_BASE:   return 1'b1;
      F7_ALT:    return (funct3 == 3'b000) || (funct3 == 3'b101);
      F7_MULDIV: return m_en;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctl_dec.sv
// rtl/ctl_dec.sv - combinational RV32I(M) decoder producing the control bundle
module ctl_dec
  import ctl_pkg::*;
#(
  parameter int RV32M = 0
) (
  input  logic [31:0] inst_i,
  output ctl_t        ctl_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);

  localparam logic M_EN = (RV32M != 0);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    ctl_o = CTL_RESET;
    legal = 1'b1;
    case (opcode)
      OP_R: begin
        ctl_o.i_format  = FMT_R;
        ctl_o.reg_write = 1'b1;
        ctl_o.muldiv    = M_EN && (funct7 == F7_MULDIV);
        legal           = r_funct7_ok(funct7, funct3, M_EN);
      end
      OP_IMM: begin
        ctl_o.i_format  = FMT_I;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_src   = 1'b1;
        ctl_o.alu_op    = ALU_IMM;
      end
      OP_LOAD: begin
        ctl_o.i_format   = FMT_I;
        ctl_o.reg_write  = 1'b1;
        ctl_o.alu_src    = 1'b1;
        ctl_o.mem_read   = 1'b1;
        ctl_o.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        ctl_o.i_format  = FMT_S;
        ctl_o.alu_src   = 1'b1;
        ctl_o.mem_write = 1'b1;
        ctl_o.alu_op    = ALU_STORE;
      end
      OP_BRANCH: begin
        ctl_o.i_format = FMT_B;
        ctl_o.bj_type  = funct3;
      end
      OP_JAL: begin
        ctl_o.i_format  = FMT_J;
        ctl_o.reg_write = 1'b1;
        ctl_o.bj_type   = BJ_JUMP;
      end
      OP_JALR: begin
        ctl_o.i_format  = FMT_I;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_src   = 1'b1;
        ctl_o.bj_type   = BJ_JUMP;
      end
      OP_LUI: begin
        ctl_o.i_format  = FMT_U;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_src   = 1'b1;
        ctl_o.u_sel     = USEL_LUI;
      end
      OP_AUIPC: begin
        ctl_o.i_format  = FMT_U;
        ctl_o.reg_write = 1'b1;
        ctl_o.alu_src   = 1'b1;
        ctl_o.u_sel     = USEL_AUIPC;
      end
      default: legal = 1'b0;
    endcase

    // an illegal word must not write state or look like any format
    if (!legal) begin
      ctl_o.reg_write  = 1'b0;
      ctl_o.mem_read   = 1'b0;
      ctl_o.mem_write  = 1'b0;
      ctl_o.mem_to_reg = 1'b0;
      ctl_o.alu_src    = 1'b0;
      ctl_o.muldiv     = 1'b0;
      ctl_o.i_format   = FMT_NONE;
      ctl_o.alu_op     = ALU_ILL;
      ctl_o.illegal    = 1'b1;
    end
    ctl_o.rd = ctl_o.reg_write ? inst_i[11:7] : 5'd0;
  end

  assign uses_rs1_o = |(ctl_o.i_format & (FMT_R | FMT_I | FMT_S | FMT_B));
  assign uses_rs2_o = |(ctl_o.i_format & (FMT_R | FMT_S | FMT_B));

endmodule

// File: rtl/ctl_pipe.sv
// rtl/ctl_pipe.sv - registered decode-control stage with valid/ready, flush and load-use bubbles
module ctl_pipe
  import ctl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LU_BUBBLES = 1,
  parameter int RV32M      = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [1:0]      out_u_sel,
  output logic [5:0]      out_i_format,
  output logic [2:0]      out_bj_type,
  output logic [1:0]      out_alu_op,
  output logic            out_mem_read,
  output logic            out_mem_to_reg,
  output logic            out_mem_write,
  output logic            out_alu_src,
  output logic            out_reg_write,
  output logic            out_muldiv,
  output logic            out_illegal,
  output logic [4:0]      out_rd
);

  localparam logic [1:0] CNT_LOAD = 2'(LU_BUBBLES - 1);

  ctl_t            dec_ctl;
  logic            uses_rs1;
  logic            uses_rs2;

  logic            valid_q, valid_d;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  ctl_t            ctl_q;
  logic [1:0]      cnt_q, cnt_d;
  logic [4:0]      haz_rd_q, haz_rd_d;

  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            dep_out;
  logic            dep_haz;
  logic            block;
  logic            accept;
  logic            xfer;
  logic            load_out;

  ctl_dec #(.RV32M(RV32M)) u_dec (
    .inst_i     (in_inst),
    .ctl_o      (dec_ctl),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign rs1     = in_inst[19:15];
  assign rs2     = in_inst[24:20];
  assign dep_out = (uses_rs1 && (rs1 == ctl_q.rd)) || (uses_rs2 && (rs2 == ctl_q.rd));
  assign dep_haz = (uses_rs1 && (rs1 == haz_rd_q)) || (uses_rs2 && (rs2 == haz_rd_q));

  // held load covers its own leaving cycle; the counter covers the bubbles after it
  assign block = (valid_q && ctl_q.mem_read && (ctl_q.rd != 5'd0) && dep_out)
              || ((cnt_q != 2'd0) && dep_haz);

  assign in_ready = !i_rst && !i_flush && !block && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;
  assign load_out = xfer && ctl_q.mem_read && (ctl_q.rd != 5'd0);

  always_comb begin
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    haz_rd_d = haz_rd_q;
    if (i_flush) begin
      valid_d  = 1'b0;
      cnt_d    = 2'd0;
      haz_rd_d = 5'd0;
    end else begin
      if (accept) begin
        valid_d = 1'b1;
      end else if (xfer) begin
        valid_d = 1'b0;
      end
      if (load_out) begin
        cnt_d    = CNT_LOAD;
        haz_rd_d = ctl_q.rd;
      end else if (cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      cnt_q    <= 2'd0;
      haz_rd_q <= 5'd0;
      inst_q   <= 32'd0;
      pc_q     <= '0;
      ctl_q    <= CTL_RESET;
    end else begin
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      haz_rd_q <= haz_rd_d;
      if (accept) begin
        inst_q <= in_inst;
        pc_q   <= in_pc;
        ctl_q  <= dec_ctl;
      end
    end
  end

  assign out_valid      = valid_q;
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_u_sel      = ctl_q.u_sel;
  assign out_i_format   = ctl_q.i_format;
  assign out_bj_type    = ctl_q.bj_type;
  assign out_alu_op     = ctl_q.alu_op;
  assign out_mem_read   = ctl_q.mem_read;
  assign out_mem_to_reg = ctl_q.mem_to_reg;
  assign out_mem_write  = ctl_q.mem_write;
  assign out_alu_src    = ctl_q.alu_src;
  assign out_reg_write  = ctl_q.reg_write;
  assign out_muldiv     = ctl_q.muldiv;
  assign out_illegal    = ctl_q.illegal;
  assign out_rd         = ctl_q.rd;

endmodule

// File: tb/tb_ctl_pipe.sv
// tb/tb_ctl_pipe.sv - scoreboard bench for ctl_pipe across three LU_BUBBLES/RV32M configurations
module tb_ctl_pipe;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  u_sel;
    logic [5:0]  fmt;
    logic [2:0]  bj;
    logic [1:0]  aop;
    logic        mr, m2r, mw, asrc, rw, md, ill;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;

  logic [2:0][88:0] obs_w;
  logic [2:0]       vld_w;
  logic [2:0]       rdy_w;
  logic [1:0]       sel = 2'd0;
  logic [88:0]      obs;

  exp_t q[$];
  bit   held = 1'b0;
  bit   exp_ready = 1'b0;
  bit   mext = 1'b0;
  int   lu = 2;
  int   cyc = 0;
  int   leave_cyc = -100;
  logic [4:0] load_rd = 5'd0;
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic        vo, ro;
    logic [31:0] oi, op;
    logic [1:0]  us, ao;
    logic [5:0]  fm;
    logic [2:0]  bj;
    logic        mr, m2r, mw, asr, rw, md, il;
    logic [4:0]  rd;
    ctl_pipe #(.XLEN(32), .LU_BUBBLES((g == 0) ? 2 : ((g == 1) ? 1 : 3)), .RV32M((g == 0) ? 0 : 1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .in_valid(in_valid), .in_ready(ro), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(vo), .out_ready(out_ready), .out_inst(oi), .out_pc(op),
      .out_u_sel(us), .out_i_format(fm), .out_bj_type(bj), .out_alu_op(ao),
      .out_mem_read(mr), .out_mem_to_reg(m2r), .out_mem_write(mw), .out_alu_src(asr),
      .out_reg_write(rw), .out_muldiv(md), .out_illegal(il), .out_rd(rd)
    );
    assign obs_w[g] = {oi, op, us, fm, bj, ao, mr, m2r, mw, asr, rw, md, il, rd};
    assign vld_w[g] = vo;
    assign rdy_w[g] = ro;
  end

  assign obs = obs_w[sel];

  function automatic exp_t ref_obs(input logic [31:0] inst, input logic [31:0] pc, input bit m);
    exp_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ill;
    e = '0;
    e.inst = inst;
    e.pc = pc;
    e.bj = 3'b010;
    f3 = inst[14:12];
    f7 = inst[31:25];
    ill = 1'b0;
    case (inst[6:0])
      7'h33: begin
        e.fmt = 6'b000001; e.rw = 1'b1; e.md = m && (f7 == 7'h01);
        ill = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)) || (m && f7 == 7'h01));
      end
      7'h13: begin e.fmt = 6'b000010; e.rw = 1'b1; e.asrc = 1'b1; e.aop = 2'b01; end
      7'h03: begin e.fmt = 6'b000010; e.rw = 1'b1; e.asrc = 1'b1; e.mr = 1'b1; e.m2r = 1'b1; end
      7'h23: begin e.fmt = 6'b000100; e.asrc = 1'b1; e.mw = 1'b1; e.aop = 2'b11; end
      7'h63: begin e.fmt = 6'b001000; e.bj = f3; end
      7'h6F: begin e.fmt = 6'b100000; e.rw = 1'b1; e.bj = 3'b011; end
      7'h67: begin e.fmt = 6'b000010; e.rw = 1'b1; e.asrc = 1'b1; e.bj = 3'b011; end
      7'h37: begin e.fmt = 6'b010000; e.rw = 1'b1; e.asrc = 1'b1; e.u_sel = 2'b01; end
      7'h17: begin e.fmt = 6'b010000; e.rw = 1'b1; e.asrc = 1'b1; e.u_sel = 2'b10; end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.fmt = 6'd0; e.rw = 1'b0; e.mr = 1'b0; e.m2r = 1'b0; e.mw = 1'b0;
      e.asrc = 1'b0; e.md = 1'b0; e.aop = 2'b10; e.ill = 1'b1;
    end
    e.rd = e.rw ? inst[11:7] : 5'd0;
    return e;
  endfunction

  function automatic bit dep(input exp_t e, input logic [4:0] r);
    bit u1, u2;
    u1 = |e.fmt[3:0];
    u2 = e.fmt[0] | e.fmt[2] | e.fmt[3];
    return (u1 && e.inst[19:15] == r) || (u2 && e.inst[24:20] == r);
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h03};
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 10);
    w[6:0] = (k == 10) ? 7'($urandom) : ops[k];
    w[11:7] = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d, cfg %0d)", name, act, exp, cyc, sel);
  endtask

  task automatic step(input bit v, input logic [31:0] inst, input bit ordy, input bit fl);
    exp_t e;
    bit dh, dw;
    @(posedge clk);
    #1;
    in_valid = v;
    in_inst = inst;
    in_pc = $urandom;
    out_ready = ordy;
    flush = fl;
    e = ref_obs(inst, in_pc, mext);
    dh = 1'b0;
    if (held) dh = q[0].mr && (q[0].rd != 5'd0) && dep(e, q[0].rd);
    dw = ((cyc - leave_cyc) < lu) && dep(e, load_rd);
    exp_ready = !fl && (!held || ordy) && !dh && !dw;
    if (v && exp_ready) q.push_back(e);
  endtask

  task automatic offer(input logic [31:0] inst);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, inst, 1'b1, 1'b0);
      if (exp_ready) break;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    exp_t r;
    r = '0;
    r.bj = 3'b010;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 89'(vld_w[sel]), 89'(0));
    chk("rst_in_ready", 89'(rdy_w[sel]), 89'(0));
    chk("rst_entry", obs, r);
    q.delete();
    held = 1'b0;
    leave_cyc = -100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    exp_ready = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", 89'(rdy_w[sel]), 89'(exp_ready));
      chk("out_valid", 89'(vld_w[sel]), 89'(held));
      if (held) begin
        chk("out_entry", obs, q[0]);
        if (out_ready) begin
          if (q[0].mr && q[0].rd != 5'd0) begin
            leave_cyc = cyc;
            load_rd = q[0].rd;
          end
          void'(q.pop_front());
          held = 1'b0;
        end
      end
      if (flush) begin
        if (held) begin
          void'(q.pop_front());
          held = 1'b0;
        end
        leave_cyc = -100;
      end
      if (q.size() != 0) held = 1'b1;
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] lw5, bne, add_dep;
    lw5 = {12'd0, 5'd2, 3'b010, 5'd5, 7'h03};
    bne = {7'd0, 5'd2, 5'd1, 3'b001, 5'd0, 7'h63};
    add_dep = r_type(7'h00, 5'd1, 5'd5, 5'd6);
    for (int ph = 0; ph < 3; ph++) begin
      sel = 2'(ph);
      mext = (ph != 0);
      lu = (ph == 0) ? 2 : ((ph == 1) ? 1 : 3);
      do_reset();
      step(1'b1, r_type(7'h00, 5'd3, 5'd2, 5'd1), 1'b1, 1'b0);
      step(1'b1, {12'd5, 5'd1, 3'b000, 5'd4, 7'h13}, 1'b1, 1'b0);
      idle(2);
      offer(lw5);
      offer(add_dep);
      idle(2);
      offer({12'd0, 5'd2, 3'b010, 5'd0, 7'h03});
      offer(r_type(7'h00, 5'd1, 5'd0, 5'd6));
      idle(2);
      offer(lw5);
      offer(r_type(7'h00, 5'd2, 5'd1, 5'd7));
      idle(2);
      offer(bne);
      for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
      idle(2);
      offer(lw5);
      step(1'b1, add_dep, 1'b1, 1'b0);
      step(1'b1, add_dep, 1'b1, 1'b1);
      offer(add_dep);
      idle(2);
      offer(32'h0000007F);
      offer(r_type(7'h01, 5'd3, 5'd2, 5'd1));
      idle(2);
      offer(bne);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(0, 3) != 0, gen_inst(), $urandom_range(0, 4) != 0,
             $urandom_range(0, 29) == 0);
      end
      idle(4);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ctl_pipe.md
# ctl_pipe

Registered, handshaked decode-control stage for the pipelined RV32I hart, sitting between the IF/ID and ID/EX boundaries. Each accepted instruction is decoded into the standard control bundle and held in a single output register. The stage has valid/ready flow control, flush on a redirect, configurable load-use bubble insertion, optional RV32M recognition and illegal-instruction flagging.

## Interface
Parameters:
- XLEN, 32: PC width.
- LU_BUBBLES, 1: bubbles forced between a load leaving and a dependent instruction appearing. Legal range 1..3.
- RV32M, 0: 1 accepts R-type funct7=0000001 as mul/div; 0 flags it illegal.

Ports:
- i_clk  in  1  clock. One clock domain.
- i_rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  redirect. Drops the held entry and the hazard state.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts in_inst/in_pc this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_inst  out  32  held instruction.
- out_pc  out  XLEN  held PC.
- out_u_sel  out  2  01 LUI, 10 AUIPC, else 00.
- out_i_format  out  6  one-hot, bit0..bit5 = R,I,S,B,U,J. 0 when illegal.
- out_bj_type  out  3  funct3 for branches; 011 for JAL/JALR; 010 otherwise.
- out_alu_op  out  2  01 ALU-I; 11 store; 10 illegal; 00 otherwise.
- out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write  out  1 each  standard control bits.
- out_muldiv  out  1  R-type funct7=0000001 with RV32M=1.
- out_illegal  out  1  unrecognised opcode or funct7.
- out_rd  out  5  inst[11:7]. Forced to 0 when out_reg_write=0.

## Operation
- Decode is combinational on in_inst. The result is registered on accept, i.e. when in_valid && in_ready.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other opcode decodes as illegal.
- R-type funct7 legality:
  - 0000000 is legal for any funct3.
  - 0100000 is legal only with funct3 000 or 101.
  - 0000001 is legal only when RV32M=1.
  - Anything else is illegal.
- An illegal decode forces reg_write=0, mem_read=0, mem_write=0, mem_to_reg=0, alu_src=0, i_format=0 and alu_op=10.
- uses_rs1 is 1 for the R, I, S and B formats. uses_rs2 is 1 for R, S and B. Both are 0 when illegal.
- Output register:
  - Loads on accept.
  - Clears out_valid on a transfer with no simultaneous accept.
  - Holds otherwise.
- Hazard state is a 2-bit counter cnt plus a 5-bit haz_rd.
- A load transfers out when out_valid && out_ready && out_mem_read && out_rd!=0. On that event: cnt <= LU_BUBBLES-1 and haz_rd <= out_rd.
- Otherwise cnt decrements when nonzero.
- dep(r) is true when the incoming instruction has (uses_rs1 && rs1==r) || (uses_rs2 && rs2==r).
- block = (out_valid && out_mem_read && out_rd!=0 && dep(out_rd)) || (cnt!=0 && dep(haz_rd)).
- in_ready = !i_rst && !i_flush && !block && (!out_valid || out_ready).
- Independent instructions are never blocked by the hazard state.
- i_flush takes priority over everything: out_valid <= 0, cnt <= 0, no accept that cycle. A transfer of the held entry in the same cycle still counts downstream.

## Timing
- Latency: instruction accepted at edge N is visible on out_* from cycle N+1.
- Throughput: 1 per cycle when there is no hazard and out_ready=1.
- Load-use: the load leaves at the end of cycle t. The dependent is accepted at the end of cycle t+LU_BUBBLES and appears at t+LU_BUBBLES+1. out_valid is 0 for exactly LU_BUBBLES cycles in between.
- Stall: while out_valid && !out_ready, all out_* are stable and in_ready=0.
- Reset values:
  - out_valid=0, cnt=0, haz_rd=0.
  - All out_* control bits=0, out_bj_type=010, out_pc=0, out_inst=0, out_rd=0.
  - in_ready=0 while i_rst is asserted.
- Reset asserted mid-stall or mid-bubble clears the entry and the counter immediately (asynchronously).

## Structure
- Shared package ctl_pkg holds:
  - opcode localparams;
  - i_format one-hot constants;
  - bj_type constants (BJ_NONE=010, BJ_JUMP=011);
  - alu_op constants;
  - the control-bundle struct typedef.
- One combinational sub-module, ctl_dec, maps (inst, RV32M) to the bundle plus uses_rs1/uses_rs2. ctl_pipe holds the register, the handshake and the hazard counter.

## Test plan
- Back-to-back ADD x1,x2,x3 / ADDI x4,x1,5 with out_ready=1 -> in_ready stays 1; outputs appear on consecutive cycles; ADDI shows alu_op=01, alu_src=1.
- LW x5,0(x2) then ADD x6,x5,x1, LU_BUBBLES=2 -> in_ready=0 for the cycle the LW transfers plus 1 cycle; out_valid=0 for exactly 2 cycles before ADD appears.
- LW x0,0(x2) then ADD x6,x0,x1 -> no bubble.
- LW x5 then independent ADD x7,x1,x2 -> no bubble.
- out_ready=0 for 3 cycles while holding BNE (funct3=001) -> out_* stable; out_bj_type=001; in_ready=0.
- i_flush on the cycle after a LW leaves, with a dependent waiting -> out_valid=0 and cnt=0. The next dependent instruction is accepted the cycle after the flush.
- Opcode 1111111, then MUL x1,x2,x3 with RV32M=0 -> out_illegal=1, reg_write=0, alu_op=10.
- The same MUL with RV32M=1 -> out_muldiv=1, out_illegal=0.
- i_rst pulsed while an entry is stalled -> out_valid=0 immediately; out_bj_type=010.
